// File: rtl/issue_unit_pkg.sv
// Shared types and helpers for the issue unit: decoded instruction layout,
// issue lane record and the pairing hazard check between the two queue heads.
package issue_unit_pkg;

  localparam int NREG_W = 5;

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] rs;
    logic [NREG_W-1:0] rt;
    logic [NREG_W-1:0] dst;
    logic              wr_reg;
    logic              is_mem;
    logic              is_br;
    logic              is_muldiv;
  } decode_t;

  typedef struct packed {
    logic    valid;
    decode_t instr;
  } issue_lane_t;

  // True when the younger entry may not issue alongside the older one:
  // RAW/WAW on the older destination, or both need the single mem / muldiv unit.
  function automatic logic pair_conflict(input decode_t older, input decode_t younger);
    logic dep;
    logic structural;
    dep = older.wr_reg && (older.dst != '0) &&
          ((younger.rs == older.dst) || (younger.rt == older.dst) ||
           (younger.wr_reg && (younger.dst == older.dst)));
    structural = (older.is_mem && younger.is_mem) ||
                 (older.is_muldiv && younger.is_muldiv);
    return dep || structural;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy vector with per-lane source/destination busy queries.
// Writebacks in the current cycle are bypassed so a freshly cleared register reads as free.
module issue_scoreboard
  import issue_unit_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic [1:0]             set_en,
  input  logic [1:0][NREG_W-1:0] set_dst,
  input  logic [1:0]             clr_en,
  input  logic [1:0][NREG_W-1:0] clr_dst,
  input  logic [1:0][NREG_W-1:0] q_rs,
  input  logic [1:0][NREG_W-1:0] q_rt,
  input  logic [1:0][NREG_W-1:0] q_dst,
  input  logic [1:0]             q_wr,
  output logic [1:0]             busy
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] avail_busy;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (clr_en[i]) clr_mask[clr_dst[i]] = 1'b1;
      if (set_en[i]) set_mask[set_dst[i]] = 1'b1;
    end
    set_mask[0] = 1'b0;
  end

  // Clear happens before set, so a register written back and re-targeted in the same cycle stays busy.
  assign avail_busy = busy_q & ~clr_mask;
  assign busy_d     = avail_busy | set_mask;

  always_comb begin
    busy = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = avail_busy[q_rs[i]] | avail_busy[q_rt[i]] |
                (q_wr[i] & avail_busy[q_dst[i]]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/issue_unit.sv
// In-order dual issue from the two queue heads into the issue/execute register pair,
// with scoreboard hazard blocking and dual-issue / bubble performance counters.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int EN_DUAL = 1,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  decode_t [1:0]          cand,
  input  logic                   queue_empty,
  input  logic                   ex_stall,
  input  logic [1:0]             wb_en,
  input  logic [1:0][NREG_W-1:0] wb_dst,
  output logic [1:0]             issued_cnt,
  output logic [1:0]             iss_valid,
  output decode_t [1:0]          iss_instr,
  output logic [CNT_W-1:0]       perf_dual,
  output logic [CNT_W-1:0]       perf_bubble
);

  issue_lane_t [1:0]      lane_q;
  issue_lane_t [1:0]      lane_d;
  logic [CNT_W-1:0]       perf_dual_q;
  logic [CNT_W-1:0]       perf_bubble_q;
  logic [1:0]             lane_busy;
  logic                   advance;
  logic                   ok0;
  logic                   ok1;
  logic [1:0]             set_en;
  logic [1:0][NREG_W-1:0] set_dst;
  logic [1:0][NREG_W-1:0] q_rs;
  logic [1:0][NREG_W-1:0] q_rt;
  logic [1:0][NREG_W-1:0] q_dst;
  logic [1:0]             q_wr;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      q_rs[i]  = cand[i].rs;
      q_rt[i]  = cand[i].rt;
      q_dst[i] = cand[i].dst;
      q_wr[i]  = cand[i].wr_reg;
    end
  end

  issue_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .set_en  (set_en),
    .set_dst (set_dst),
    .clr_en  (wb_en),
    .clr_dst (wb_dst),
    .q_rs    (q_rs),
    .q_rt    (q_rt),
    .q_dst   (q_dst),
    .q_wr    (q_wr),
    .busy    (lane_busy)
  );

  // Gating on resetn keeps issued_cnt at zero while the queue is held in reset.
  always_comb begin
    advance = resetn & ~ex_stall & ~flush & ~queue_empty;
    ok0     = advance & cand[0].valid & ~lane_busy[0];
    ok1     = (EN_DUAL != 0) & ok0 & cand[1].valid & ~cand[1].is_br &
              ~lane_busy[1] & ~pair_conflict(cand[0], cand[1]);
    issued_cnt = {1'b0, ok0} + {1'b0, ok1};
  end

  always_comb begin
    set_en     = {ok1 & cand[1].wr_reg, ok0 & cand[0].wr_reg};
    set_dst[0] = cand[0].dst;
    set_dst[1] = cand[1].dst;
  end

  always_comb begin
    lane_d = '0;
    if (ok0) begin
      lane_d[0].valid = 1'b1;
      lane_d[0].instr = cand[0];
    end
    if (ok1) begin
      lane_d[1].valid = 1'b1;
      lane_d[1].instr = cand[1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q        <= '0;
      perf_dual_q   <= '0;
      perf_bubble_q <= '0;
    end else begin
      if (flush) begin
        lane_q <= '0;
      end else if (!ex_stall) begin
        lane_q <= lane_d;
      end
      if (!flush) begin
        if (issued_cnt == 2'd2) perf_dual_q <= perf_dual_q + CNT_W'(1);
        if ((issued_cnt == 2'd0) && !queue_empty) perf_bubble_q <= perf_bubble_q + CNT_W'(1);
      end
    end
  end

  assign iss_valid    = {lane_q[1].valid, lane_q[0].valid};
  assign iss_instr[0] = lane_q[0].instr;
  assign iss_instr[1] = lane_q[1].instr;
  assign perf_dual    = perf_dual_q;
  assign perf_bubble  = perf_bubble_q;

endmodule
